// File: rtl/uart_bytes_tx_arb.sv
// rtl/uart_bytes_tx_arb.sv - round-robin frame arbiter feeding one byte-level UART transmitter
// Optional: UART_BYTES_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority.
module uart_bytes_tx_arb #(
    parameter int REQ_NUM  = 4,
    parameter int BYTES    = 5,
    parameter int BYTE_GAP = 0
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [REQ_NUM-1:0]         req,
    input  logic [REQ_NUM*BYTES*8-1:0] req_data,
    output logic [REQ_NUM-1:0]         gnt,
    output logic [REQ_NUM-1:0]         done,
    output logic                       busy,
    output logic [7:0]                 tx_byte,
    output logic                       tx_en,
    input  logic                       tx_busy
);

    localparam int FW = BYTES * 8;
    localparam int PW = $clog2(REQ_NUM);
    localparam int CW = $clog2(BYTES + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] ACK  = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;
    localparam logic [2:0] FIN  = 3'd5;

    logic [2:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] hi;
    logic [PW-1:0] lo;
    logic [PW-1:0] sel;
    logic          hi_vld;
    logic [FW-1:0] frame;
    logic [FW-1:0] shift_reg;
    logic [FW-1:0] shift_next;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    gap_cnt;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
    always_comb begin
        hi     = '0;
        lo     = '0;
        hi_vld = 1'b0;
        for (int j = REQ_NUM - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo = PW'(j);
                if (PW'(j) >= ptr) begin
                    hi     = PW'(j);
                    hi_vld = 1'b1;
                end
            end
        end
    end

    assign sel = hi_vld ? hi : lo;

    always_comb begin
        frame = '0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (sel == PW'(j)) begin
                frame = req_data[j*FW +: FW];
            end
        end
    end

    assign shift_next = shift_reg << 8;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tx_byte   <= 8'h00;
            tx_en     <= 1'b0;
        end else begin
            gnt   <= '0;
            done  <= '0;
            tx_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win       <= sel;
                        shift_reg <= frame;
                        tx_byte   <= frame[FW-1 -: 8];
                        gnt       <= REQ_NUM'(1) << sel;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        tx_en <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (tx_busy) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        shift_reg <= shift_next;
                        tx_byte   <= shift_next[FW-1 -: 8];
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt == CW'(BYTES - 1)) begin
                            done  <= REQ_NUM'(1) << win;
                            state <= FIN;
                        end else if (BYTE_GAP > 0) begin
                            gap_cnt <= 8'd0;
                            state   <= GAP;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'(BYTE_GAP - 1)) begin
                        state <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                FIN: begin
                    // done is visible this cycle; busy drops after it.
                    busy     <= 1'b0;
                    byte_cnt <= '0;
`ifdef UART_BYTES_TX_ARB_FIXED_PRIO_EN
                    ptr      <= '0;
`else
                    ptr      <= (win == PW'(REQ_NUM - 1)) ? '0 : win + 1'b1;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bytes_tx_arb.sv
// tb/tb_uart_bytes_tx_arb.sv - randomized and directed bench with a frame-level reference model
module tb_uart_bytes_tx_arb;

    localparam int N  = 4;
    localparam int B  = 5;
    localparam int FW = B * 8;
    localparam int M  = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   hold_len = 2170;
    int   posted[N];
    logic [FW-1:0] data_q[N][M];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GAP = (g == 0) ? 0 : 10;
        logic [N-1:0]    req, gnt, done;
        logic [N*FW-1:0] req_data;
        logic            busy, tx_en, tx_busy;
        logic [7:0]      tx_byte;
        int              served[N] = '{default: 0};
        int              hold;

        // Each requester holds req while it has an ungranted frame queued.
        always_comb begin
            req      = '0;
            req_data = '0;
            for (int k = 0; k < N; k++) begin
                req[k]              = posted[k] > served[k];
                req_data[k*FW +: FW] = data_q[k][served[k] % M];
            end
        end

        always @(posedge clk) begin
            for (int k = 0; k < N; k++) begin
                if (gnt[k]) served[k] <= served[k] + 1;
            end
        end

        // Transmitter: busy from the cycle after tx_en for a fixed hold; the gap instance drops early.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tx_busy <= 1'b0;
                hold    <= 0;
            end else if (tx_en) begin
                tx_busy <= 1'b1;
                hold    <= ((g == 0) ? hold_len : hold_len / 4 + 1) - 1;
            end else if (tx_busy) begin
                if (hold == 0) tx_busy <= 1'b0;
                else hold <= hold - 1;
            end
        end

        uart_bytes_tx_arb #(.REQ_NUM(N), .BYTES(B), .BYTE_GAP(GAP)) dut (
            .sys_clk  (clk),
            .sys_rst_n(rst_n),
            .req      (req),
            .req_data (req_data),
            .gnt      (gnt),
            .done     (done),
            .busy     (busy),
            .tx_byte  (tx_byte),
            .tx_en    (tx_en),
            .tx_busy  (tx_busy)
        );

        int            m_ptr = 0, m_win = 0, m_en = 0, m_falls = 0, exp_en = -1, exp_done = -1;
        bit            m_act = 0, prev_busy = 0;
        logic [N-1:0]  exp_gnt = '0;
        logic [FW-1:0] m_frame = '0;
        int            glog[$];
        logic [7:0]    blog[$];

        always @(negedge clk) begin
            if (!rst_n) begin
                chk("reset_outputs", {46'd0, gnt, done, busy, tx_en, tx_byte}, 64'd0);
                m_ptr = 0; m_act = 0; exp_gnt = '0; exp_en = -1; exp_done = -1; prev_busy = 0;
            end else begin
                chk("gnt", gnt, exp_gnt);
                chk("busy", busy, m_act);
                chk("tx_en", tx_en, cyc == exp_en);
                chk("tx_en_vs_tx_busy", tx_en & tx_busy, 1'b0);
                chk("done", done, (cyc == exp_done) ? (N'(1) << m_win) : N'(0));
                if (gnt != 0) glog.push_back($clog2(gnt));
                if (tx_en) begin
                    blog.push_back(tx_byte);
                    if (m_en < B) chk("tx_byte", tx_byte, 8'(m_frame >> (8 * (B - 1 - m_en))));
                    m_en++;
                end
                if (m_act && prev_busy && !tx_busy) begin
                    m_falls++;
                    if (m_falls == B) exp_done = cyc + 1;
                    else exp_en = cyc + GAP + 2;
                end
                prev_busy = tx_busy;
                exp_gnt = '0;
                if (!m_act && req != 0) begin
                    m_win   = pick(req, m_ptr);
                    exp_gnt = N'(1) << m_win;
                    m_frame = data_q[m_win][served[m_win] % M];
                    m_act   = 1; m_en = 0; m_falls = 0;
                    exp_en  = cyc + 2; exp_done = -1;
                end else if (m_act && cyc == exp_done) begin
                    m_act = 0;
`ifdef UART_BYTES_TX_ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (m_win + 1) % N;
`endif
                end
            end
        end
    end

    task automatic post(input int k, input logic [FW-1:0] d);
        data_q[k][posted[k]] = d;
        posted[k]++;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        bit ok = 0;
        while (n < lim && !ok) begin
            @(negedge clk);
            n++;
            ok = (u[0].req == 0) && (u[1].req == 0) && !u[0].busy && !u[1].busy;
        end
        chk("idle_within_bound", ok, 1'b1);
    endtask

    logic [7:0]    exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int            exp_fx[4];
    logic [FW-1:0] w;
    int            g0, g1, b0, n;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            posted[k] = 0;
            for (int i = 0; i < M; i++) data_q[k][i] = {$urandom, $urandom};
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single frame, full-length transmitter hold
        g0 = u[0].glog.size(); b0 = u[0].blog.size();
        post(0, 40'h1122334455);
        wait_idle(40000);
        chk("single_gnt_count", u[0].glog.size() - g0, 1);
        chk("single_gnt_idx", u[0].glog[g0], 0);
        chk("single_byte_count", u[0].blog.size() - b0, 5);
        for (int i = 0; i < 5; i++) chk("single_byte", u[0].blog[b0 + i], exp_b[i]);

        // Byte order reassembles to the original word
        hold_len = 50;
        post(3, 40'hA5C31E7F00);
        wait_idle(5000);
        w = '0;
        for (int i = 0; i < 5; i++) w = {w[31:0], u[0].blog[u[0].blog.size() - 5 + i]};
        chk("loopback_word", w, 40'hA5C31E7F00);
        w = '0;
        for (int i = 0; i < 5; i++) w = {w[31:0], u[1].blog[u[1].blog.size() - 5 + i]};
        chk("loopback_word_gap", w, 40'hA5C31E7F00);

        // Continuous contention from all four requesters
        hold_len = 20;
        g0 = u[0].glog.size(); g1 = u[1].glog.size();
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) post(k, {$urandom, $urandom});
        wait_idle(20000);
        chk("rr_gnt_count", u[0].glog.size() - g0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("rr_order", u[0].glog[g0 + i], i % 4);
            chk("rr_order_gap", u[1].glog[g1 + i], i % 4);
        end

        // Reset after two bytes of requester 2's frame
        post(2, {$urandom, $urandom});
        n = 0;
        while (n < 20000 && !(u[0].m_act && u[0].m_falls == 2)) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte2", u[0].m_falls, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        g0 = u[0].glog.size();
        post(1, {$urandom, $urandom});
        post(2, {$urandom, $urandom});
        wait_idle(5000);
        chk("post_reset_first", u[0].glog[g0], 1);
        chk("post_reset_second", u[0].glog[g0 + 1], 2);

        // req=1010 held: three frames from 1, one from 3
`ifdef UART_BYTES_TX_ARB_FIXED_PRIO_EN
        exp_fx = '{1, 1, 1, 3};
`else
        exp_fx = '{3, 1, 1, 1};
`endif
        g0 = u[0].glog.size();
        for (int r = 0; r < 3; r++) post(1, {$urandom, $urandom});
        post(3, {$urandom, $urandom});
        wait_idle(5000);
        for (int i = 0; i < 4; i++) chk("prio_order", u[0].glog[g0 + i], exp_fx[i]);

        // Randomized arrivals and transmitter timing
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, N - 1);
            hold_len = $urandom_range(1, 40);
            if (posted[k] < M - 1) post(k, {$urandom, $urandom});
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        wait_idle(60000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
